// File: rtl/ibex_register_file_prof.sv
// ibex_register_file_prof
//
// Flip-flop register file with a configurable number of read and write
// ports. Every register also has a saturating access counter. The counters
// can be streamed out, one register per beat, through a valid/ready dump
// port. R0 always reads as zero and ignores writes, but accesses to R0 are
// still counted.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   re_i                  per read port enable (affects profiling only)
//   raddr_i / rdata_o     packed read addresses (5 bits each) and read data
//   we_i/waddr_i/wdata_i  packed write enables, addresses and data
//   dump_req_i/clr_i      start a counter dump, optionally read-and-clear
//   dump_valid_o/ready_i  beat handshake
//   dump_idx_o/count_o    register index and counter value of current beat
//   dump_done_o           one-cycle pulse after the last beat
//   dump_busy_o           high while a dump is in progress
module ibex_register_file_prof #(
    parameter bit          RV32E         = 1'b0,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 1,
    parameter int unsigned CountWidth    = 16,
    parameter bit          WriteBypass   = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReadPorts-1:0]            re_i,
    input  logic [NumReadPorts*5-1:0]          raddr_i,
    output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
    input  logic [NumWritePorts-1:0]           we_i,
    input  logic [NumWritePorts*5-1:0]         waddr_i,
    input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
    input  logic                               dump_req_i,
    input  logic                               dump_clr_i,
    output logic                               dump_valid_o,
    input  logic                               dump_ready_i,
    output logic [4:0]                         dump_idx_o,
    output logic [CountWidth-1:0]              dump_count_o,
    output logic                               dump_done_o,
    output logic                               dump_busy_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 2 ** AddrWidth;

    typedef enum logic [1:0] {
        StIdle,
        StDump,
        StDone
    } dumpState_e;

    logic [DataWidth-1:0]  rf_q     [NumWords];
    logic [DataWidth-1:0]  rf_d     [NumWords];
    logic [CountWidth-1:0] count_q  [NumWords];
    logic [CountWidth-1:0] count_d  [NumWords];
    logic                  wrEn     [NumWords];
    logic [DataWidth-1:0]  wrData   [NumWords];
    logic [2:0]            inc      [NumWords];
    logic [AddrWidth-1:0]  rAddr    [NumReadPorts];
    logic [AddrWidth-1:0]  wAddr    [NumWritePorts];

    dumpState_e            dumpState_q;
    logic [4:0]            dumpIdx_q;
    logic                  clrMode_q;
    logic                  dumpValid_q;
    logic                  dumpBusy_q;
    logic                  dumpDone_q;
    logic                  clrHit;

    // Unpack the port addresses, keeping only the bits that select a
    // register in this configuration.
    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            rAddr[p] = raddr_i[5*p +: AddrWidth];
        end
        for (int w = 0; w < NumWritePorts; w++) begin
            wAddr[w] = waddr_i[5*w +: AddrWidth];
        end
    end

    // Per-register write decode. Ports are scanned in ascending order so the
    // highest-index port targeting a register supplies its data. R0 never
    // gets a write enable.
    always_comb begin
        for (int r = 0; r < NumWords; r++) begin
            wrEn[r]   = 1'b0;
            wrData[r] = '0;
            for (int w = 0; w < NumWritePorts; w++) begin
                if (we_i[w] && (wAddr[w] == AddrWidth'(r)) && (r != 0)) begin
                    wrEn[r]   = 1'b1;
                    wrData[r] = wdata_i[DataWidth*w +: DataWidth];
                end
            end
            rf_d[r] = wrEn[r] ? wrData[r] : rf_q[r];
        end
    end

    // Combinational read ports. With bypass enabled, a same-cycle write to
    // the addressed register is forwarded; R0 is never written so it stays 0.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (rAddr[p] != '0) begin
                rdata_o[DataWidth*p +: DataWidth] = rf_q[rAddr[p]];
            end
            if (WriteBypass && wrEn[rAddr[p]]) begin
                rdata_o[DataWidth*p +: DataWidth] = wrData[rAddr[p]];
            end
        end
    end

    // Count how many enabled read and write ports touched each register this
    // cycle. At most six ports exist, so three bits always suffice.
    always_comb begin
        for (int r = 0; r < NumWords; r++) begin
            inc[r] = 3'd0;
            for (int p = 0; p < NumReadPorts; p++) begin
                if (re_i[p] && (rAddr[p] == AddrWidth'(r))) begin
                    inc[r] = inc[r] + 3'd1;
                end
            end
            for (int w = 0; w < NumWritePorts; w++) begin
                if (we_i[w] && (wAddr[w] == AddrWidth'(r))) begin
                    inc[r] = inc[r] + 3'd1;
                end
            end
        end
    end

    assign clrHit = dumpValid_q && dump_ready_i && clrMode_q;

    // Next counter values. The add is one bit wider than the counter so the
    // carry out flags saturation. A counter handshaked in clear mode restarts
    // from this cycle's increment instead of being zeroed, so no access is lost.
    always_comb begin
        logic [CountWidth-1:0] base;
        logic [CountWidth:0]   sum;
        base = '0;
        sum  = '0;
        for (int r = 0; r < NumWords; r++) begin
            base = (clrHit && (dumpIdx_q[AddrWidth-1:0] == AddrWidth'(r))) ? '0 : count_q[r];
            sum  = {1'b0, base} + (CountWidth+1)'(inc[r]);
            count_d[r] = sum[CountWidth] ? '1 : sum[CountWidth-1:0];
        end
    end

    // Register array and counters. Reset clears everything and overrides any
    // write or increment arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumWords; r++) begin
                rf_q[r]    <= '0;
                count_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumWords; r++) begin
                rf_q[r]    <= rf_d[r];
                count_q[r] <= count_d[r];
            end
        end
    end

    // Dump sequencer. Walks every register index once, advancing only on a
    // handshake, then spends one cycle in DONE to pulse dump_done_o. Valid,
    // busy and done are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dumpState_q <= StIdle;
            dumpIdx_q   <= '0;
            clrMode_q   <= 1'b0;
            dumpValid_q <= 1'b0;
            dumpBusy_q  <= 1'b0;
            dumpDone_q  <= 1'b0;
        end else begin
            case (dumpState_q)
                StIdle: begin
                    if (dump_req_i) begin
                        dumpState_q <= StDump;
                        dumpIdx_q   <= '0;
                        clrMode_q   <= dump_clr_i;
                        dumpValid_q <= 1'b1;
                        dumpBusy_q  <= 1'b1;
                    end
                end
                StDump: begin
                    if (dump_ready_i) begin
                        if (dumpIdx_q == 5'(NumWords - 1)) begin
                            dumpState_q <= StDone;
                            dumpValid_q <= 1'b0;
                            dumpDone_q  <= 1'b1;
                        end else begin
                            dumpIdx_q <= dumpIdx_q + 5'd1;
                        end
                    end
                end
                StDone: begin
                    dumpState_q <= StIdle;
                    dumpIdx_q   <= '0;
                    dumpBusy_q  <= 1'b0;
                    dumpDone_q  <= 1'b0;
                end
                default: begin
                    dumpState_q <= StIdle;
                    dumpIdx_q   <= '0;
                    dumpValid_q <= 1'b0;
                    dumpBusy_q  <= 1'b0;
                    dumpDone_q  <= 1'b0;
                end
            endcase
        end
    end

    // Beat contents are forced to zero outside a valid beat; the count is the
    // live registered counter so it follows updates during backpressure.
    assign dump_valid_o = dumpValid_q;
    assign dump_busy_o  = dumpBusy_q;
    assign dump_done_o  = dumpDone_q;
    assign dump_idx_o   = dumpValid_q ? dumpIdx_q : 5'd0;
    assign dump_count_o = dumpValid_q ? count_q[dumpIdx_q[AddrWidth-1:0]] : '0;

endmodule

// File: tb/tb_ibex_register_file_prof.sv
// Testbench for ibex_register_file_prof. Two instances share all stimulus:
// dutA has a 4-bit counter and no bypass, dutB has a 16-bit counter and
// bypass. A behavioural model of the register file, counters and dump
// sequence predicts every output each cycle.
module tb_ibex_register_file_prof;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        dumpReq;
    logic        dumpClr;
    logic        dumpReady;

    logic [63:0] rdataA, rdataB;
    logic        validA, validB, doneA, doneB, busyA, busyB;
    logic [4:0]  idxA, idxB;
    logic [3:0]  countA;
    logic [15:0] countB;

    // Staged inputs for the next cycle, copied onto the DUT at the falling edge
    logic        stRst;
    logic [1:0]  stRe;
    logic [4:0]  stRaddr [2];
    logic [1:0]  stWe;
    logic [4:0]  stWaddr [2];
    logic [31:0] stWdata [2];
    logic        stReq, stClr, stReady;

    // Reference model state
    logic [31:0] mRf   [32];
    int unsigned mCntA [32];
    int unsigned mCntB [32];
    bit          mActive, mDoneSt, mClr, modelValid;
    int          mIdx;

    int total, bad;

    always #5 clk = ~clk;

    ibex_register_file_prof #(
        .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
        .CountWidth(4), .WriteBypass(1'b0)
    ) dutA (
        .clk_i(clk), .rst_i(rst), .re_i(re), .raddr_i(raddr), .rdata_o(rdataA),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .dump_req_i(dumpReq), .dump_clr_i(dumpClr), .dump_valid_o(validA),
        .dump_ready_i(dumpReady), .dump_idx_o(idxA), .dump_count_o(countA),
        .dump_done_o(doneA), .dump_busy_o(busyA)
    );

    ibex_register_file_prof #(
        .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
        .CountWidth(16), .WriteBypass(1'b1)
    ) dutB (
        .clk_i(clk), .rst_i(rst), .re_i(re), .raddr_i(raddr), .rdata_o(rdataB),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .dump_req_i(dumpReq), .dump_clr_i(dumpClr), .dump_valid_o(validB),
        .dump_ready_i(dumpReady), .dump_idx_o(idxB), .dump_count_o(countB),
        .dump_done_o(doneB), .dump_busy_o(busyB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStim();
        stRst   = 1'b0;
        stRe    = 2'b00;
        stWe    = 2'b00;
        stReq   = 1'b0;
        stClr   = 1'b0;
        stReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stRaddr[i] = 5'd0;
            stWaddr[i] = 5'd0;
            stWdata[i] = 32'd0;
        end
    endtask

    // Compare every DUT output against what the model predicts for the
    // current state and the staged inputs.
    task automatic checkCycle();
        logic [31:0] expOld, expByp;
        logic [4:0]  a;
        for (int p = 0; p < 2; p++) begin
            a      = stRaddr[p];
            expOld = (a == 5'd0) ? 32'd0 : mRf[a];
            expByp = expOld;
            if (a != 5'd0) begin
                for (int w = 0; w < 2; w++) begin
                    if (stWe[w] && stWaddr[w] == a) expByp = stWdata[w];
                end
            end
            checkOutput($sformatf("rdataA%0d", p), 64'(rdataA[32*p +: 32]), 64'(expOld));
            checkOutput($sformatf("rdataB%0d", p), 64'(rdataB[32*p +: 32]), 64'(expByp));
        end
        checkOutput("validA", 64'(validA), 64'(mActive));
        checkOutput("validB", 64'(validB), 64'(mActive));
        checkOutput("busyA", 64'(busyA), 64'(mActive || mDoneSt));
        checkOutput("busyB", 64'(busyB), 64'(mActive || mDoneSt));
        checkOutput("doneA", 64'(doneA), 64'(mDoneSt));
        checkOutput("doneB", 64'(doneB), 64'(mDoneSt));
        checkOutput("idxA", 64'(idxA), mActive ? 64'(mIdx) : 64'd0);
        checkOutput("idxB", 64'(idxB), mActive ? 64'(mIdx) : 64'd0);
        checkOutput("countA", 64'(countA), mActive ? 64'(mCntA[mIdx]) : 64'd0);
        checkOutput("countB", 64'(countB), mActive ? 64'(mCntB[mIdx]) : 64'd0);
    endtask

    // Advance the model by one clock edge using the staged inputs.
    task automatic updateModel();
        int unsigned inc [32];
        int unsigned nA, nB;
        bit          hs;
        if (stRst) begin
            for (int r = 0; r < 32; r++) begin
                mRf[r] = 32'd0; mCntA[r] = 0; mCntB[r] = 0;
            end
            mActive = 0; mDoneSt = 0; mClr = 0; mIdx = 0; modelValid = 1;
            return;
        end
        for (int r = 0; r < 32; r++) inc[r] = 0;
        for (int p = 0; p < 2; p++) if (stRe[p]) inc[stRaddr[p]]++;
        for (int w = 0; w < 2; w++) if (stWe[w]) inc[stWaddr[w]]++;
        hs = mActive && stReady;
        for (int r = 0; r < 32; r++) begin
            if (hs && mClr && r == mIdx) begin
                nA = inc[r]; nB = inc[r];
            end else begin
                nA = mCntA[r] + inc[r]; nB = mCntB[r] + inc[r];
            end
            mCntA[r] = (nA > 15) ? 15 : nA;
            mCntB[r] = (nB > 65535) ? 65535 : nB;
        end
        for (int w = 0; w < 2; w++) begin
            if (stWe[w] && stWaddr[w] != 5'd0) mRf[stWaddr[w]] = stWdata[w];
        end
        if (mDoneSt) begin
            mDoneSt = 0;
        end else if (mActive) begin
            if (stReady) begin
                if (mIdx == 31) begin
                    mActive = 0; mDoneSt = 1;
                end else begin
                    mIdx++;
                end
            end
        end else if (stReq) begin
            mActive = 1; mIdx = 0; mClr = stClr;
        end
    endtask

    // Drive the staged inputs for one cycle, check outputs mid-cycle, then
    // step the model at the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        rst       = stRst;
        re        = stRe;
        raddr     = {stRaddr[1], stRaddr[0]};
        we        = stWe;
        waddr     = {stWaddr[1], stWaddr[0]};
        wdata     = {stWdata[1], stWdata[0]};
        dumpReq   = stReq;
        dumpClr   = stClr;
        dumpReady = stReady;
        #1;
        if (modelValid) checkCycle();
        @(posedge clk);
        updateModel();
    endtask

    // Run one full dump with light random read traffic. readyMode 0 keeps
    // ready high, 1 toggles it, 2 randomises it. abortAt >= 0 asserts reset
    // on that beat.
    task automatic runDump(input bit clr, input int readyMode, input int abortAt);
        bit aborted;
        aborted = 0;
        clearStim();
        stReq = 1'b1;
        stClr = clr;
        applyStimulus();
        for (int c = 0; c < 300 && (mActive || mDoneSt); c++) begin
            clearStim();
            if (readyMode == 0)      stReady = 1'b1;
            else if (readyMode == 1) stReady = c[0];
            else                     stReady = 1'($urandom_range(0, 1));
            stRe       = 2'($urandom_range(0, 3));
            stRaddr[0] = 5'($urandom_range(0, 31));
            stRaddr[1] = 5'($urandom_range(0, 31));
            if (abortAt >= 0 && mActive && mIdx == abortAt) begin
                stRst   = 1'b1;
                aborted = 1;
            end
            applyStimulus();
        end
        if (mActive || mDoneSt) checkOutput("dumpTimeout", 64'd0, 64'd1);
        if (abortAt >= 0) checkOutput("dumpAbortReached", 64'(aborted), 64'd1);
        clearStim();
        applyStimulus();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        modelValid = 0;
        mActive = 0; mDoneSt = 0; mClr = 0; mIdx = 0;

        clearStim();
        stRst = 1'b1;
        applyStimulus();
        applyStimulus();
        stRst = 1'b0;
        applyStimulus();

        // Write 0xDEADBEEF to x5, then read it back
        clearStim();
        stWe = 2'b01; stWaddr[0] = 5'd5; stWdata[0] = 32'hDEADBEEF;
        applyStimulus();
        clearStim();
        stRe = 2'b01; stRaddr[0] = 5'd5;
        applyStimulus();

        // Write to x0 is discarded but counted
        clearStim();
        stWe = 2'b01; stWaddr[0] = 5'd0; stWdata[0] = 32'hFFFFFFFF;
        applyStimulus();
        clearStim();
        stRe = 2'b11; stRaddr[0] = 5'd0; stRaddr[1] = 5'd5;
        applyStimulus();

        // Both ports write x7, port 1 wins
        clearStim();
        stWe = 2'b11; stWaddr[0] = 5'd7; stWaddr[1] = 5'd7;
        stWdata[0] = 32'h1111; stWdata[1] = 32'h2222;
        applyStimulus();
        clearStim();
        stRaddr[1] = 5'd7;
        applyStimulus();

        // Same-cycle write and read of x3
        clearStim();
        stWe = 2'b01; stWaddr[0] = 5'd3; stWdata[0] = 32'hA5;
        stRe = 2'b10; stRaddr[1] = 5'd3;
        applyStimulus();

        // Eight cycles of dual-port reads of x9 saturate the 4-bit counter
        for (int i = 0; i < 8; i++) begin
            clearStim();
            stRe = 2'b11; stRaddr[0] = 5'd9; stRaddr[1] = 5'd9;
            applyStimulus();
        end

        // Three accesses to x1
        for (int i = 0; i < 3; i++) begin
            clearStim();
            stRe = 2'b01; stRaddr[0] = 5'd1;
            applyStimulus();
        end

        runDump(1'b1, 1, -1);
        runDump(1'b0, 0, -1);
        runDump(1'b1, 2, 10);
        runDump(1'b0, 0, -1);

        // Random traffic with occasional dumps and resets
        for (int i = 0; i < 1500; i++) begin
            clearStim();
            stRst      = ($urandom_range(0, 499) == 0);
            stRe       = 2'($urandom_range(0, 3));
            stRaddr[0] = 5'($urandom_range(0, 31));
            stRaddr[1] = 5'($urandom_range(0, 31));
            stWe       = 2'($urandom_range(0, 3));
            stWaddr[0] = 5'($urandom_range(0, 7));
            stWaddr[1] = 5'($urandom_range(0, 7));
            stWdata[0] = $urandom;
            stWdata[1] = $urandom;
            stReq      = ($urandom_range(0, 19) == 0);
            stClr      = 1'($urandom_range(0, 1));
            stReady    = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibex_register_file_prof.md
# ibex_register_file_prof

Parametrised flip-flop register file with configurable read and write port counts, plus per-register access profiling. Each register keeps a saturating access counter, and the counters can be streamed out through a valid/ready dump interface. The block replaces the single-write/dual-read register file in the ID stage on profiling-enabled and dual-issue configurations. R0 reads as zero, and writes to R0 are discarded.

## Interface
- RV32E, 0: 1 selects 16 registers (ADDR_WIDTH=4); 0 selects 32 registers (ADDR_WIDTH=5). NUM_WORDS = 2**ADDR_WIDTH.
- DataWidth, 32: register width.
- NumReadPorts, 2: number of read ports, 1..4.
- NumWritePorts, 1: number of write ports, 1..2.
- CountWidth, 16: access counter width, 4..32.
- WriteBypass, 0: 1 forwards same-cycle write data to reads.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- re_i  in  NumReadPorts  per-port read enable; affects profiling only.
- raddr_i  in  NumReadPorts*5  packed read addresses; port p occupies bits [5p+4:5p].
- rdata_o  out  NumReadPorts*DataWidth  packed read data.
- we_i  in  NumWritePorts  per-port write enable.
- waddr_i  in  NumWritePorts*5  packed write addresses.
- wdata_i  in  NumWritePorts*DataWidth  packed write data.
- dump_req_i  in  1  start a counter dump; sampled only in IDLE.
- dump_clr_i  in  1  sampled together with dump_req_i; selects read-and-clear mode.
- dump_valid_o  out  1  dump beat valid.
- dump_ready_i  in  1  consumer accepts the current beat.
- dump_idx_o  out  5  register index of the current beat.
- dump_count_o  out  CountWidth  counter value of the current beat.
- dump_done_o  out  1  one-cycle pulse after the last beat.
- dump_busy_o  out  1  high while the FSM is outside IDLE.

## Operation
- Addresses are truncated to ADDR_WIDTH bits. When RV32E=1, bit 4 is ignored.
- Reads are combinational: rdata for port p = rf[raddr_p], and reading R0 returns 0.
- Writes: register r loads wdata on the next edge if any enabled write port targets it and r≠0.
- Write conflict: when two write ports target the same register, the higher-index port wins.
- Bypass: when WriteBypass=1, a read that matches an enabled write to the same address (≠0) in the same cycle returns the winning wdata. When WriteBypass=0, it returns the old value.
- Profiling: every cycle, counter[r] increments by inc[r], where inc[r] = (number of ports p with re_i[p] and raddr_p==r) + (number of write ports with we_i and waddr==r).
  - R0 accesses are counted.
  - The sum is computed at full width and saturates at 2^CountWidth-1; it never wraps.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP on dump_req_i. clr_mode <= dump_clr_i, idx <= 0.
  - DUMP: dump_valid_o=1, dump_idx_o=idx, dump_count_o=counter[idx] (the registered value).
    - On dump_valid_o && dump_ready_i: if idx==NUM_WORDS-1, go to DONE; otherwise idx++.
    - With clr_mode=1, the handshaked counter loads inc[idx] (saturated) instead of counter+inc, so that cycle's accesses are not lost.
  - DONE: dump_done_o=1 for exactly one cycle, then return to IDLE.
  - dump_req_i is ignored in DUMP and DONE.
- Counters not being handshaked keep incrementing during a dump.

## Timing
- Reset (rst_i=1 at an edge): all registers 0, all counters 0, FSM in IDLE, idx 0, clr_mode 0.
  - Outputs: dump_valid_o, dump_done_o, dump_busy_o = 0; dump_idx_o = 0; dump_count_o = 0.
  - Reset takes priority over any write, increment or handshake in the same cycle.
  - Reset mid-dump aborts the dump, with no dump_done_o pulse.
- dump_idx_o and dump_count_o are 0 whenever dump_valid_o=0.
- Write-to-read latency is 1 cycle, or 0 with WriteBypass=1.
- Counter update latency is 1 cycle.
- Dump timing:
  - dump_req_i accepted at edge N.
  - First beat valid in the cycle after edge N.
  - Minimum dump length is NUM_WORDS beats plus 1 DONE cycle.
  - dump_busy_o is high from the cycle after edge N through the DONE cycle.
- Backpressure: while dump_ready_i=0, beat index and validity hold. dump_count_o tracks live counter updates until the handshake.

## Test plan
- Reset, then write 0xDEADBEEF to x5 on port 0 -> next cycle rdata for x5 = 0xDEADBEEF. Write to x0 -> x0 still reads 0, and counter[0] increments by 1.
- NumWritePorts=2, both ports write x7 (0x1111 on port 0, 0x2222 on port 1) -> x7 = 0x2222 and counter[7] += 2.
- WriteBypass=1: write x3 = 0xA5 while reading x3 in the same cycle -> rdata = 0xA5. With WriteBypass=0 the same stimulus returns the old value 0.
- CountWidth=4: read x9 on 2 ports for 8 cycles -> counter[9] = 15, holding at 15 with no wrap.
- Dump with clr=1 and ready toggling every other cycle, after 3 accesses to x1:
  - Beats come out in index order 0..NUM_WORDS-1, and beat 1 shows count 3.
  - One dump_done_o pulse follows the last beat.
  - Counters are then 0, except a counter accessed during its own handshake cycle, which holds that cycle's inc.
- rst_i asserted at beat 10 of a dump -> next cycle dump_valid_o=0, dump_busy_o=0, all counters 0, no dump_done_o pulse.
